seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE, default 4: consecutive clk cycles a digit's an/seg must hold before capture.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1024: consecutive all-off cycles (an=4'hF) that declare blanking.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 seg  input  7  active-low segments {g,f,e,d,c,b,a}, synchronous to clk.
REQ-006 an  input  4  active-low digit enables; an[3]=thousands … an[0]=ones.
REQ-007 digits  output  16  captured BCD frame {thousands,hundreds,tens,ones}.
REQ-008 value  output  14  binary equivalent of digits (0..9999).
REQ-009 frame_valid  output  1  one-cycle pulse when a new complete frame is loaded.
REQ-010 stable  output  1  high while the last two complete frames were identical.
REQ-011 blanked  output  1  high while the display is in a blank (flash-off) interval.
REQ-012 seg_err  output  1  high when the last attempted frame contained an undecodable digit.

Function
REQ-013 SHALL decode only these seg patterns (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; any other pattern is invalid.
REQ-014 SHALL treat an as a valid digit select only when exactly one bit is low; other non-4'hF patterns reset the settle counter and capture nothing.
REQ-015 SHALL restart the settle counter whenever an or seg changes; a digit is captured once, in the cycle the counter reaches SETTLE, into the staging register for its position, and its bit is set in a 4-bit seen mask.
REQ-016 SHALL not recapture the same position until the an selection changes.
REQ-017 When seen mask becomes 4'hF, SHALL in the next cycle load digits and value, pulse frame_valid, and clear the mask (latency 1 cycle after the fourth capture).
REQ-018 SHALL compute value = 1000*d3 + 100*d2 + 10*d1 + d0 registered with digits (same cycle); no saturation needed.
REQ-019 If any staged digit of the frame was invalid, SHALL not update digits/value, SHALL not pulse frame_valid, SHALL set seg_err, clear the mask, and clear stable.
REQ-020 seg_err SHALL clear on the next successful frame load.
REQ-021 stable SHALL set on a frame load equal to the previous loaded digits and clear on a load that differs.
REQ-022 FSM states: SCAN (collecting digits), BLANK (display off).
REQ-023 SCAN->BLANK when an=4'hF for BLANK_CYCLES consecutive cycles; blanked=1 in BLANK; the seen mask clears on entry.
REQ-024 BLANK->SCAN on the first cycle any an bit is low; blanked clears that cycle; digits/value hold through BLANK.
REQ-025 Shorter all-off gaps (<BLANK_CYCLES, e.g. inter-digit dead time) SHALL be ignored without clearing the mask.
REQ-026 Blank counter SHALL saturate at BLANK_CYCLES; settle counter SHALL saturate at SETTLE.

Reset
REQ-027 On rst_n low, asynchronously: digits=0, value=0, frame_valid=0, stable=0, blanked=0, seg_err=0, mask=0, counters=0, state=SCAN.
REQ-028 Reset mid-frame SHALL discard all staged digits; the first frame after release requires four fresh captures.

Structure
REQ-029 Package seg_pkg SHALL hold the ten segment pattern constants, the state enum, and SETTLE/BLANK_CYCLES defaults.
REQ-030 One combinational sub-module seg7_to_bcd SHALL map seg to {valid, bcd[3:0]}; all state lives in seg_scan_decoder.

Verification
REQ-031 Scan 1,2,3,4 (an=7,B,D,E), each held 8 cycles -> one frame_valid, digits=16'h1234, value=1234, seg_err=0.
REQ-032 Two identical scans of 0205 -> frame_valid twice, value=205, stable=1 after the second; then a 0204 scan -> stable=0.
REQ-033 Digit held only 3 cycles with SETTLE=4 -> not captured, no frame_valid; outputs hold the prior value.
REQ-034 seg=7F (blank pattern) on the tens position -> seg_err=1, digits unchanged; next valid scan of 9999 -> value=9999, seg_err=0.
REQ-035 an=F for 1024 cycles -> blanked=1, value held; resume scan of 0150 -> blanked=0 on the first active cycle, value=150.
REQ-036 rst_n asserted after two digits captured -> all outputs 0 immediately; after release, two further digits produce no frame_valid.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg -- shared constants and types for the seven-segment scan decoder.
//   SEG_0..SEG_9      : active-low {g,f,e,d,c,b,a} patterns for the ten digits
//   state_t           : scan/blank state of the frame collector
//   SETTLE_DEF        : default settle length (cycles)
//   BLANK_CYCLES_DEF  : default all-off length that declares blanking
//   bcd_to_bin()      : four BCD digits -> binary 0..9999
package seg_pkg;

    localparam int SETTLE_DEF       = 4;
    localparam int BLANK_CYCLES_DEF = 1024;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    typedef enum logic {
        SCAN  = 1'b0,
        BLANK = 1'b1
    } state_t;

    function automatic logic [13:0] bcd_to_bin(input logic [15:0] d);
        return 14'(d[15:12]) * 14'd1000 + 14'(d[11:8]) * 14'd100
             + 14'(d[7:4]) * 14'd10 + 14'(d[3:0]);
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd -- combinational segment-pattern decoder.
//   seg   : active-low segments {g,f,e,d,c,b,a}
//   valid : pattern is one of the ten digit shapes
//   bcd   : decoded digit (0 when invalid)
module seg7_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] bcd
);

    always_comb begin
        valid = 1'b1;
        bcd   = 4'd0;
        case (seg)
            SEG_0: bcd = 4'd0;
            SEG_1: bcd = 4'd1;
            SEG_2: bcd = 4'd2;
            SEG_3: bcd = 4'd3;
            SEG_4: bcd = 4'd4;
            SEG_5: bcd = 4'd5;
            SEG_6: bcd = 4'd6;
            SEG_7: bcd = 4'd7;
            SEG_8: bcd = 4'd8;
            SEG_9: bcd = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder -- recovers the number shown on a multiplexed 4-digit
// seven-segment display by watching its drive lines.
//   clk, rst_n  : clock, asynchronous active-low reset
//   seg, an     : active-low segment and digit-enable lines (an[3]=thousands)
//   digits      : last complete BCD frame {thousands,hundreds,tens,ones}
//   value       : binary value of digits
//   frame_valid : one-cycle pulse when digits/value load
//   stable      : last two loaded frames were identical
//   blanked     : display is in a long all-off interval
//   seg_err     : last attempted frame held an undecodable digit
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int SETTLE       = SETTLE_DEF,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [13:0] value,
    output logic        frame_valid,
    output logic        stable,
    output logic        blanked,
    output logic        seg_err
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE);
    localparam logic [BW-1:0] BLANK_MAX  = BW'(BLANK_CYCLES);

    state_t         state;
    logic [6:0]     seg_q;
    logic [3:0]     an_q;
    logic [SW-1:0]  settle_cnt, settle_nxt;
    logic [BW-1:0]  blank_cnt, blank_nxt;
    logic           done;          // current an selection already captured
    logic [3:0]     mask, mask_nxt;
    logic [3:0][3:0] stage;
    logic [3:0]     stage_ok;

    logic           dec_valid;
    logic [3:0]     dec_bcd;
    logic           one_hot, an_chg, in_chg, capture, blank_hit, frame_rdy;
    logic [1:0]     pos;

    seg7_to_bcd u_dec (
        .seg   (seg),
        .valid (dec_valid),
        .bcd   (dec_bcd)
    );

    always_comb begin
        one_hot = 1'b1;
        pos     = 2'd0;
        case (an)
            4'b1110: pos = 2'd0;
            4'b1101: pos = 2'd1;
            4'b1011: pos = 2'd2;
            4'b0111: pos = 2'd3;
            default: one_hot = 1'b0;
        endcase
    end

    assign an_chg = (an != an_q);
    assign in_chg = an_chg || (seg != seg_q);

    // settle_cnt = number of consecutive cycles the current an/seg pair has
    // been held, counting this one; zero while no single digit is selected.
    always_comb begin
        if (!one_hot)                      settle_nxt = '0;
        else if (in_chg)                   settle_nxt = SW'(1);
        else if (settle_cnt == SETTLE_MAX) settle_nxt = settle_cnt;
        else                               settle_nxt = settle_cnt + 1'b1;
    end

    // A segment change under the same selection restarts settling but may not
    // capture the position a second time; only a new an selection re-arms it.
    assign capture = one_hot && (settle_nxt == SETTLE_MAX) && !(done && !an_chg);

    always_comb begin
        if (an != 4'hF)                   blank_nxt = '0;
        else if (blank_cnt == BLANK_MAX)  blank_nxt = blank_cnt;
        else                              blank_nxt = blank_cnt + 1'b1;
    end

    assign blank_hit = (state == SCAN) && (blank_nxt == BLANK_MAX);
    assign frame_rdy = (mask == 4'hF);

    always_comb begin
        mask_nxt = frame_rdy ? 4'h0 : mask;
        if (capture)   mask_nxt[pos] = 1'b1;
        if (blank_hit) mask_nxt = 4'h0;
    end

    // Gated by an so blanked drops in the very cycle scanning resumes,
    // not one cycle later when the state register catches up.
    assign blanked = (state == BLANK) && (an == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SCAN;
            seg_q       <= 7'h7F;
            an_q        <= 4'hF;
            settle_cnt  <= '0;
            blank_cnt   <= '0;
            done        <= 1'b0;
            mask        <= 4'h0;
            stage       <= '0;
            stage_ok    <= 4'h0;
            digits      <= 16'h0;
            value       <= 14'd0;
            frame_valid <= 1'b0;
            stable      <= 1'b0;
            seg_err     <= 1'b0;
        end else begin
            seg_q       <= seg;
            an_q        <= an;
            settle_cnt  <= settle_nxt;
            blank_cnt   <= blank_nxt;
            mask        <= mask_nxt;
            frame_valid <= 1'b0;

            if (an_chg) done <= 1'b0;
            if (capture) begin
                stage[pos]    <= dec_bcd;
                stage_ok[pos] <= dec_valid;
                done          <= 1'b1;
            end

            if (frame_rdy) begin
                if (&stage_ok) begin
                    digits      <= stage;
                    value       <= bcd_to_bin(stage);
                    frame_valid <= 1'b1;
                    stable      <= (stage == digits);
                    seg_err     <= 1'b0;
                end else begin
                    seg_err <= 1'b1;
                    stable  <= 1'b0;
                end
            end

            case (state)
                SCAN:    if (blank_hit)   state <= BLANK;
                BLANK:   if (an != 4'hF)  state <= SCAN;
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder -- scoreboard bench: stimulus tasks feed a digit-level
// reference model that queues expected frames; a negedge monitor pops and
// compares whenever frame_valid is seen.
module tb_seg_scan_decoder;

    localparam int SETTLE = 4;
    localparam int BLANK  = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [13:0] value;
    logic        frame_valid, stable, blanked, seg_err;

    seg_scan_decoder #(.SETTLE(SETTLE), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .digits(digits),
        .value(value), .frame_valid(frame_valid), .stable(stable),
        .blanked(blanked), .seg_err(seg_err)
    );

    always #5 clk = ~clk;

    logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct packed {
        logic [15:0] d;
        logic [13:0] v;
        logic        st;
    } exp_t;

    exp_t        q[$];
    int          checks = 0, failures = 0, n_fv = 0;
    int          m_stage[4];
    bit          m_ok[4];
    bit   [3:0]  m_mask = 4'h0;
    logic [15:0] m_digits = 16'h0;
    bit          m_stable = 1'b0, m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int decode(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (pat[i] == s) return i;
        return -1;
    endfunction

    // Reference model: one call per digit that was held long enough to settle.
    task automatic model_capture(input int p, input logic [6:0] s);
        int d;
        exp_t e;
        logic [15:0] nd;
        d = decode(s);
        m_stage[p] = (d < 0) ? 0 : d;
        m_ok[p]    = (d >= 0);
        m_mask[p]  = 1'b1;
        if (m_mask == 4'hF) begin
            m_mask = 4'h0;
            if (m_ok[0] && m_ok[1] && m_ok[2] && m_ok[3]) begin
                nd = {4'(m_stage[3]), 4'(m_stage[2]), 4'(m_stage[1]), 4'(m_stage[0])};
                e.d  = nd;
                e.v  = 14'(m_stage[3] * 1000 + m_stage[2] * 100 + m_stage[1] * 10 + m_stage[0]);
                e.st = (nd == m_digits);
                m_digits = nd;
                m_stable = e.st;
                m_err    = 1'b0;
                q.push_back(e);
            end else begin
                m_err    = 1'b1;
                m_stable = 1'b0;
            end
        end
    endtask

    task automatic show(input int p, input logic [6:0] s, input int hold);
        logic [3:0] one;
        one = 4'b0001;
        an  = ~(one << p);
        seg = s;
        if (hold >= SETTLE) model_capture(p, s);
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        an  = 4'hF;
        seg = 7'h7F;
        if (n >= BLANK) m_mask = 4'h0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [6:0] p3, p2, p1, p0, input int hold);
        show(3, p3, hold);
        show(2, p2, hold);
        show(1, p1, hold);
        show(0, p0, hold);
        gap(3);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && frame_valid) begin
            n_fv++;
            if (q.size() == 0) chk("unexpected_frame_valid", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_digits", digits, e.d);
                chk("sb_value", value, e.v);
                chk("sb_stable", stable, e.st);
                chk("sb_seg_err", seg_err, 0);
            end
        end
    end

    initial begin
        int fv0, nf;
        int dd[4];
        logic [6:0] p[4];
        rst_n = 1'b0; an = 4'hF; seg = 7'h7F;
        #3;
        chk("rst_digits", digits, 0);
        chk("rst_value", value, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_stable", stable, 0);
        chk("rst_blanked", blanked, 0);
        chk("rst_seg_err", seg_err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 1234
        fv0 = n_fv;
        frame(pat[1], pat[2], pat[3], pat[4], 8);
        chk("f1234_fv", n_fv - fv0, 1);
        chk("f1234_digits", digits, 16'h1234);
        chk("f1234_value", value, 1234);
        chk("f1234_err", seg_err, 0);

        // 0205 twice, then 0204
        frame(pat[0], pat[2], pat[0], pat[5], 8);
        frame(pat[0], pat[2], pat[0], pat[5], 8);
        chk("f0205_value", value, 205);
        chk("f0205_stable", stable, 1);
        frame(pat[0], pat[2], pat[0], pat[4], 8);
        chk("f0204_stable", stable, 0);

        // ones held 3 cycles, and a two-hot an: nothing captured there
        fv0 = n_fv;
        show(3, pat[5], 8); show(2, pat[6], 8); show(1, pat[7], 8); show(0, pat[8], 3);
        gap(5);
        an = 4'b0011; seg = pat[1];
        repeat (8) @(posedge clk); #1;
        gap(5);
        chk("short_no_fv", n_fv - fv0, 0);
        chk("short_hold_digits", digits, 16'h0204);

        // blank pattern on tens
        frame(pat[3], pat[3], 7'h7F, pat[3], 8);
        chk("err_seg_err", seg_err, 1);
        chk("err_digits", digits, 16'h0204);
        chk("err_stable", stable, 0);
        frame(pat[9], pat[9], pat[9], pat[9], 8);
        chk("f9999_value", value, 9999);
        chk("f9999_err", seg_err, 0);

        // short all-off gap mid-frame is ignored
        show(3, pat[4], 8); show(2, pat[3], 8);
        gap(20);
        show(1, pat[2], 8); show(0, pat[1], 8);
        gap(3);
        chk("gap_value", value, 4321);

        // blanking: two digits staged, then a long off interval clears them
        show(3, pat[8], 8); show(2, pat[8], 8);
        an = 4'hF; seg = 7'h7F; m_mask = 4'h0;
        repeat (BLANK - 1) @(posedge clk);
        @(negedge clk) chk("blank_before", blanked, 0);
        @(posedge clk);
        @(negedge clk) chk("blank_set", blanked, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("blank_value_hold", value, 4321);
        fv0 = n_fv;
        an = 4'b1101; seg = pat[5];
        #1 chk("blank_clear_first", blanked, 0);
        show(1, pat[5], 8); show(0, pat[0], 8);
        gap(3);
        chk("blank_mask_cleared", n_fv - fv0, 0);
        frame(pat[0], pat[1], pat[5], pat[0], 8);
        chk("f0150_value", value, 150);
        chk("f0150_blanked", blanked, 0);

        // reset mid-frame
        show(3, pat[6], 8); show(2, pat[7], 8);
        rst_n = 1'b0; an = 4'hF; seg = 7'h7F;
        m_mask = 4'h0; m_digits = 16'h0; m_stable = 1'b0; m_err = 1'b0;
        #1;
        chk("mrst_digits", digits, 0);
        chk("mrst_value", value, 0);
        chk("mrst_stable", stable, 0);
        chk("mrst_err", seg_err, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        fv0 = n_fv;
        show(1, pat[1], 8); show(0, pat[2], 8);
        gap(4);
        chk("mrst_no_fv", n_fv - fv0, 0);

        // random frames
        for (int f = 0; f < 40; f++) begin
            if (f == 0 || $urandom_range(0, 3) != 0)
                for (int k = 0; k < 4; k++) dd[k] = $urandom_range(0, 9);
            for (int k = 3; k >= 0; k--) begin
                p[k] = ($urandom_range(0, 11) == 0) ? 7'($urandom) : pat[dd[k]];
                show(k, p[k], $urandom_range(2, 9));
            end
            nf = $urandom_range(0, 4);
            if (nf > 0) gap(nf);
        end
        gap(10);
        chk("end_queue_empty", q.size(), 0);
        chk("end_digits", digits, m_digits);
        chk("end_seg_err", seg_err, m_err);
        chk("end_stable", stable, m_stable);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
